// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC Montgomery-ladder sequencer.
// Sequencer states, operand slot numbering and the operand word-count helper.
package ecc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    FIXUP,
    WAITF,
    DONE
  } state_e;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_RX   = 0;
  localparam int unsigned SLOT_RY   = 1;
  localparam int unsigned SLOT_RB   = 2;
  localparam int unsigned SLOT_K    = 3;

  function automatic int unsigned words_per_op(input int unsigned width,
                                               input int unsigned din_w);
    return width / din_w;
  endfunction

endpackage

// File: rtl/ecc_word_loader.sv
// Deserialises Rx, Ry, Rb and k from a DIN_W-bit bus, MS word first per operand.
// Tracks the 4-slot word counter and the loaded flag.
module ecc_word_loader
  import ecc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIN_W = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en_i,
  input  logic [DIN_W-1:0] din_i,
  input  logic             clear_i,
  input  logic             zero_res_i,
  output logic             loaded_o,
  output logic [WIDTH-1:0] rx_o,
  output logic [WIDTH-1:0] ry_o,
  output logic [WIDTH-1:0] rb_o,
  output logic [WIDTH-1:0] k_o
);

  localparam int unsigned TOTAL  = NUM_SLOTS * WORDS;
  localparam int unsigned CNT_W  = $clog2(TOTAL);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            loaded_q, loaded_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] op_q, op_d;
  logic [SLOT_W-1:0]               slot;
  logic [WIDTH+DIN_W-1:0]          shifted;

  // NOTE: every combinational output gets a default before the case/if logic,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    op_d     = op_q;
    slot     = SLOT_W'(cnt_q / CNT_W'(WORDS));
    shifted  = {op_q[slot], din_i};
    if (load_en_i) begin
      op_d[slot] = shifted[WIDTH-1:0];
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        loaded_d = 1'b1;
      end else begin
        // Any word other than the last, including a wrap-around restart, invalidates the load.
        cnt_d    = cnt_q + CNT_W'(1);
        loaded_d = 1'b0;
      end
    end
    if (clear_i) begin
      loaded_d = 1'b0;
    end
    if (zero_res_i) begin
      op_d[SLOT_RX] = '0;
      op_d[SLOT_RY] = WIDTH'(1);
    end
  end

  // NOTE: the operand registers are ordinary flops with a defined reset value,
  // not a RAM, so resetting them is both legal and required here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      op_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      op_q     <= op_d;
    end
  end

  assign loaded_o = loaded_q;
  assign rx_o     = op_q[SLOT_RX];
  assign ry_o     = op_q[SLOT_RY];
  assign rb_o     = op_q[SLOT_RB];
  assign k_o      = op_q[SLOT_K];

endmodule

// File: rtl/ecc_ladder_ctrl.sv
// Montgomery-ladder sequencer: walks k MSB to LSB, one handshaked core step per bit
// with a lazy-swap bit, then a fix-up swap, and latches the results in DONE.
module ecc_ladder_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = 128,
  parameter  int unsigned DIN_W = 32,
  localparam int unsigned WORDS = words_per_op(WIDTH, DIN_W),
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_en,
  input  logic [DIN_W-1:0] din,
  input  logic             start,
  input  logic             core_done,
  output logic             core_start,
  output logic             swap,
  output logic             busy,
  output logic             done,
  output logic             zero_k,
  output logic             load_err,
  output logic [WIDTH-1:0] opt_Rx,
  output logic [WIDTH-1:0] opt_Ry,
  output logic [WIDTH-1:0] opt_Rb,
  output logic [IDX_W-1:0] bit_idx
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               prev_q, prev_d;
  logic               zero_k_q, zero_k_d;
  logic               load_err_q, load_err_d;
  logic [WIDTH-1:0]   opt_rx_q, opt_rx_d;
  logic [WIDTH-1:0]   opt_ry_q, opt_ry_d;
  logic [WIDTH-1:0]   opt_rb_q, opt_rb_d;

  logic               loaded;
  logic [WIDTH-1:0]   rx, ry, rb, k;
  logic               k_is_zero;

  assign k_is_zero = (k == '0);

  ecc_word_loader #(
    .WIDTH (WIDTH),
    .DIN_W (DIN_W),
    .WORDS (WORDS)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_en_i  (data_en && (state_q == IDLE)),
    .din_i      (din),
    .clear_i    (state_q == DONE),
    .zero_res_i ((state_q == CHECK) && k_is_zero),
    .loaded_o   (loaded),
    .rx_o       (rx),
    .ry_o       (ry),
    .rb_o       (rb),
    .k_o        (k)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    prev_d     = prev_q;
    zero_k_d   = zero_k_q;
    load_err_d = load_err_q;
    opt_rx_d   = opt_rx_q;
    opt_ry_d   = opt_ry_q;
    opt_rb_d   = opt_rb_q;
    core_start = 1'b0;
    swap       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // Uses the registered loaded flag, so a word arriving with start does not count yet.
        if (start) begin
          if (loaded) begin
            load_err_d = 1'b0;
            state_d    = CHECK;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (k_is_zero) begin
          zero_k_d = 1'b1;
          state_d  = DONE;
        end else begin
          zero_k_d  = 1'b0;
          bit_idx_d = IDX_W'(WIDTH - 1);
          prev_d    = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        swap       = k[bit_idx_q] ^ prev_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          prev_d = k[bit_idx_q];
          if (bit_idx_q == '0) begin
            state_d = FIXUP;
          end else begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
            state_d   = ISSUE;
          end
        end
      end
      FIXUP: begin
        core_start = 1'b1;
        swap       = prev_q;
        state_d    = WAITF;
      end
      WAITF: begin
        if (core_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        opt_rx_d = rx;
        opt_ry_d = ry;
        opt_rb_d = rb;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      prev_q     <= 1'b0;
      zero_k_q   <= 1'b0;
      load_err_q <= 1'b0;
      opt_rx_q   <= '0;
      opt_ry_q   <= '0;
      opt_rb_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      prev_q     <= prev_d;
      zero_k_q   <= zero_k_d;
      load_err_q <= load_err_d;
      opt_rx_q   <= opt_rx_d;
      opt_ry_q   <= opt_ry_d;
      opt_rb_q   <= opt_rb_d;
    end
  end

  assign zero_k   = zero_k_q;
  assign load_err = load_err_q;
  assign opt_Rx   = opt_rx_q;
  assign opt_Ry   = opt_ry_q;
  assign opt_Rb   = opt_rb_q;
  assign bit_idx  = bit_idx_q;

endmodule

// File: tb/tb_ecc_ladder_ctrl.sv
// Scoreboard bench for ecc_ladder_ctrl: stimulus pushes expected swap steps and results,
// a monitor pops and compares whenever the DUT issues a core step or signals done.
module tb_ecc_ladder_ctrl;

  localparam int W     = 128;
  localparam int DW    = 32;
  localparam int WORDS = W / DW;
  localparam int NW    = 4 * WORDS;
  localparam int IW    = $clog2(W);
  localparam int LIMIT = 5000;

  logic          clk;
  logic          rst;
  logic          data_en;
  logic [DW-1:0] din;
  logic          start;
  logic          core_done;
  logic          core_start;
  logic          swap;
  logic          busy;
  logic          done;
  logic          zero_k;
  logic          load_err;
  logic [W-1:0]  opt_Rx;
  logic [W-1:0]  opt_Ry;
  logic [W-1:0]  opt_Rb;
  logic [IW-1:0] bit_idx;

  ecc_ladder_ctrl #(.WIDTH(W), .DIN_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_en    (data_en),
    .din        (din),
    .start      (start),
    .core_done  (core_done),
    .core_start (core_start),
    .swap       (swap),
    .busy       (busy),
    .done       (done),
    .zero_k     (zero_k),
    .load_err   (load_err),
    .opt_Rx     (opt_Rx),
    .opt_Ry     (opt_Ry),
    .opt_Rb     (opt_Rb),
    .bit_idx    (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          swp;
    logic [IW-1:0] idx;
  } step_t;

  typedef struct {
    logic         zero;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic [W-1:0] rb;
  } res_t;

  step_t step_q[$];
  res_t  res_q[$];

  int          core_lat = 0;
  logic [DW-1:0] words [NW];
  int          wcnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  function automatic logic [W-1:0] get_op(input int slot);
    logic [W-1:0] v = '0;
    for (int i = 0; i < WORDS; i++) begin
      v = (v << DW) | W'(words[slot*WORDS + i]);
    end
    return v;
  endfunction

  // Reference core: answers each step request after 1+core_lat cycles in WAIT.
  initial begin
    int cnt;
    cnt = -1;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) cnt = -1;
      else if (cnt == 0) begin
        core_done = 1'b1;
        cnt = -1;
      end else if (cnt > 0) cnt--;
      else if (core_start) cnt = core_lat;
    end
  end

  // Monitor: compares every step and every completion against the scoreboard.
  initial begin
    bit    opt_pend;
    res_t  r;
    step_t s;
    opt_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (opt_pend) begin
          check("opt_Rx", opt_Rx, r.rx);
          check("opt_Ry", opt_Ry, r.ry);
          check("opt_Rb", opt_Rb, r.rb);
          opt_pend = 1'b0;
        end
        if (core_start) begin
          if (step_q.size() == 0) flag_fail("extra_core_start");
          else begin
            s = step_q.pop_front();
            check("swap", W'(swap), W'(s.swp));
            check("bit_idx", W'(bit_idx), W'(s.idx));
          end
        end
        if (done) begin
          check("steps_remaining", W'(step_q.size()), W'(0));
          if (res_q.size() == 0) flag_fail("unexpected_done");
          else begin
            r = res_q.pop_front();
            check("zero_k", W'(zero_k), W'(r.zero));
            opt_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] w);
    data_en = 1'b1;
    din     = w;
    words[wcnt] = w;
    wcnt = (wcnt + 1) % NW;
    @(negedge clk);
    data_en = 1'b0;
  endtask

  task automatic load_ops(input logic [W-1:0] rx, input logic [W-1:0] ry,
                          input logic [W-1:0] rb, input logic [W-1:0] k);
    logic [W-1:0] ops [4];
    ops[0] = rx; ops[1] = ry; ops[2] = rb; ops[3] = k;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < WORDS; i++)
        send_word(ops[s][W-1-i*DW -: DW]);
  endtask

  // Ladder model: step i swaps when k[i] differs from the bit above it; fix-up swaps on k[0].
  task automatic push_expect;
    logic [W-1:0] k;
    logic [W:0]   kx;
    step_t        s;
    res_t         r;
    k  = get_op(3);
    kx = {1'b0, k};
    if (k != '0) begin
      for (int i = W - 1; i >= 0; i--) begin
        s.swp = kx[i] ^ kx[i+1];
        s.idx = IW'(i);
        step_q.push_back(s);
      end
      s.swp = k[0];
      s.idx = '0;
      step_q.push_back(s);
    end
    r.zero = (k == '0);
    r.rx   = r.zero ? '0 : get_op(0);
    r.ry   = r.zero ? W'(1) : get_op(1);
    r.rb   = get_op(2);
    res_q.push_back(r);
  endtask

  task automatic run_op(input int lat, input bit noise);
    int cyc;
    int exp_cyc;
    core_lat = lat;
    exp_cyc  = 2 + ((get_op(3) != '0) ? (W + 1) * (2 + lat) : 0);
    push_expect();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("load_err_after_start", W'(load_err), W'(0));
    check("busy_after_start", W'(busy), W'(1));
    while (!done && cyc < LIMIT) begin
      if (noise) begin
        data_en = 1'($urandom_range(0, 1));
        din     = $urandom();
        start   = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    data_en = 1'b0;
    start   = 1'b0;
    check("start_to_done_cycles", W'(cyc), W'(exp_cyc));
    repeat (3) @(negedge clk);
    check("busy_after_done", W'(busy), W'(0));
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst     = 1'b1;
    data_en = 1'b0;
    din     = '0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_core_start", W'(core_start), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_load_err", W'(load_err), W'(0));
    check("rst_opt_Rx", opt_Rx, W'(0));
    check("rst_bit_idx", W'(bit_idx), W'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed k=5 with zero and seven extra core cycles
    load_ops({4{32'h11111111}}, {4{32'h22222222}}, {4{32'h33333333}}, W'(5));
    run_op(0, 1'b0);
    load_ops({4{32'h11111111}}, {4{32'h22222222}}, {4{32'h33333333}}, W'(5));
    run_op(7, 1'b0);

    // Zero scalar
    load_ops(rnd_w(), rnd_w(), rnd_w(), '0);
    run_op(1, 1'b0);

    // Incomplete load then completion
    for (int i = 0; i < 10; i++) send_word($urandom());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("partial_load_err", W'(load_err), W'(1));
    check("partial_busy", W'(busy), W'(0));
    @(negedge clk);
    check("partial_busy_held", W'(busy), W'(0));
    for (int i = 0; i < 6; i++) send_word($urandom());
    run_op(0, 1'b0);

    // Randomized runs, one with input noise while busy
    for (int n = 0; n < 4; n++) begin
      load_ops(rnd_w(), rnd_w(), rnd_w(), rnd_w());
      run_op(int'($urandom_range(0, 3)), (n == 2));
    end

    // Reset in the middle of the ladder
    load_ops(rnd_w(), rnd_w(), rnd_w(), rnd_w() | {1'b1, {(W-1){1'b0}}});
    core_lat = 1;
    push_expect();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(busy && !core_start && bit_idx == IW'(60)) && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    check("reached_bit60", W'(guard < LIMIT), W'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", W'(busy), W'(0));
    check("async_rst_core_start", W'(core_start), W'(0));
    check("async_rst_bit_idx", W'(bit_idx), W'(0));
    check("async_rst_opt_Rx", opt_Rx, W'(0));
    check("async_rst_opt_Rb", opt_Rb, W'(0));
    step_q.delete();
    res_q.delete();
    wcnt = 0;
    for (int i = 0; i < NW; i++) words[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_load_err", W'(load_err), W'(1));
    check("post_rst_busy", W'(busy), W'(0));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
